smmha_lin_streamer: RTL and testbench

Parametrised multi-channel streamer for the smmha accelerator. It provides NB_LD load channels (TCDM to stream) and NB_ST store channels (stream to TCDM), each with its own linear address generator (base, stride, length). Load channels buffer data internally with credit-based request throttling. The block sits between the smmha controller/engine and the TCDM master ports.

---
 rtl/smmha_lin_streamer.sv | 256 +++++++++++++++++++++++++
 tb/tb_smmha_lin_streamer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smmha_lin_streamer.sv
// smmha_lin_streamer: multi-channel linear streamer between the smmha engine
// and its TCDM master ports.
//   NB_LD load channels:  TCDM read -> per-channel FWFT FIFO -> valid/ready stream.
//                         Requests are credit-throttled so that in-flight plus
//                         buffered words never exceed FIFO_DEPTH.
//   NB_ST store channels: valid/ready stream -> one-entry register -> TCDM write.
// Each channel owns an address generator (byte base, byte stride, word length),
// start/busy/done handshake. clear_i aborts every channel synchronously;
// enable_i gates issue of new work while pending requests and responses complete.
module smmha_lin_streamer #(
    parameter int unsigned NB_LD      = 2,
    parameter int unsigned NB_ST      = 1,
    parameter int unsigned DW         = 32,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   enable_i,
    // load channels
    input  logic [NB_LD-1:0]       ld_start_i,
    input  logic [NB_LD*32-1:0]    ld_base_i,
    input  logic [NB_LD*32-1:0]    ld_stride_i,
    input  logic [NB_LD*LEN_W-1:0] ld_len_i,
    output logic [NB_LD-1:0]       ld_busy_o,
    output logic [NB_LD-1:0]       ld_done_o,
    output logic [NB_LD-1:0]       ld_tcdm_req_o,
    output logic [NB_LD*32-1:0]    ld_tcdm_add_o,
    input  logic [NB_LD-1:0]       ld_tcdm_gnt_i,
    input  logic [NB_LD*DW-1:0]    ld_tcdm_r_data_i,
    input  logic [NB_LD-1:0]       ld_tcdm_r_valid_i,
    output logic [NB_LD-1:0]       ld_valid_o,
    output logic [NB_LD*DW-1:0]    ld_data_o,
    input  logic [NB_LD-1:0]       ld_ready_i,
    // store channels
    input  logic [NB_ST-1:0]       st_start_i,
    input  logic [NB_ST*32-1:0]    st_base_i,
    input  logic [NB_ST*32-1:0]    st_stride_i,
    input  logic [NB_ST*LEN_W-1:0] st_len_i,
    output logic [NB_ST-1:0]       st_busy_o,
    output logic [NB_ST-1:0]       st_done_o,
    input  logic [NB_ST-1:0]       st_valid_i,
    input  logic [NB_ST*DW-1:0]    st_data_i,
    output logic [NB_ST-1:0]       st_ready_o,
    output logic [NB_ST-1:0]       st_tcdm_req_o,
    output logic [NB_ST*32-1:0]    st_tcdm_add_o,
    output logic [NB_ST*DW-1:0]    st_tcdm_data_o,
    input  logic [NB_ST-1:0]       st_tcdm_gnt_i
);

    localparam int unsigned AW = 32;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {LD_IDLE, LD_RUN, LD_DRAIN} ld_state_e;
    typedef enum logic       {ST_IDLE, ST_RUN}           st_state_e;

    for (genvar i = 0; i < NB_LD; i++) begin : g_ld
        ld_state_e         state;
        logic [AW-1:0]     addr, stride;
        logic [LEN_W-1:0]  len, issued, issued_n;
        logic [CW-1:0]     outstanding, count, out_n, count_n;
        logic [CW:0]       credit_n;
        logic [PW-1:0]     wptr, rptr;
        logic [DW-1:0]     mem [FIFO_DEPTH];
        logic              req, busy, done;
        logic              gnt_hit, push, pop;
        logic [LEN_W-1:0]  len_in;

        assign len_in   = ld_len_i[i*LEN_W +: LEN_W];
        assign gnt_hit  = req & ld_tcdm_gnt_i[i];
        // Responses seen while idle belong to an aborted transfer and are dropped.
        assign push     = ld_tcdm_r_valid_i[i] & (state != LD_IDLE);
        assign pop      = (count != '0) & ld_ready_i[i];
        assign issued_n = issued + LEN_W'(gnt_hit);
        assign out_n    = outstanding + CW'(gnt_hit) - CW'(push);
        assign count_n  = count + CW'(push) - CW'(pop);
        assign credit_n = (CW+1)'(out_n) + (CW+1)'(count_n);

        // Channel FSM, address generator, credit and FIFO pointer bookkeeping.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state       <= LD_IDLE;
                addr        <= '0;
                stride      <= '0;
                len         <= '0;
                issued      <= '0;
                outstanding <= '0;
                count       <= '0;
                wptr        <= '0;
                rptr        <= '0;
                req         <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b0;
            end else if (clear_i) begin
                state       <= LD_IDLE;
                issued      <= '0;
                outstanding <= '0;
                count       <= '0;
                wptr        <= '0;
                rptr        <= '0;
                req         <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b0;
            end else begin
                done        <= 1'b0;
                outstanding <= out_n;
                count       <= count_n;
                if (push) wptr <= wptr + PW'(1);
                if (pop)  rptr <= rptr + PW'(1);
                case (state)
                    LD_IDLE: begin
                        if (ld_start_i[i]) begin
                            if (len_in != '0) begin
                                addr   <= ld_base_i[i*AW +: AW];
                                stride <= ld_stride_i[i*AW +: AW];
                                len    <= len_in;
                                issued <= '0;
                                busy   <= 1'b1;
                                state  <= LD_RUN;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    LD_RUN: begin
                        issued <= issued_n;
                        if (gnt_hit) addr <= addr + stride;
                        // A raised request is held until granted; otherwise
                        // re-evaluate against length, credit and enable.
                        if (req && !ld_tcdm_gnt_i[i]) begin
                            req <= 1'b1;
                        end else begin
                            req <= (issued_n < len) && (credit_n < DEPTH_C) && enable_i;
                        end
                        if (gnt_hit && (issued_n == len)) state <= LD_DRAIN;
                    end
                    LD_DRAIN: begin
                        req <= 1'b0;
                        if ((outstanding == '0) && (count == '0)) begin
                            state <= LD_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= LD_IDLE;
                endcase
            end
        end

        // FIFO storage; contents are don't-care until pushed.
        always_ff @(posedge clk_i) begin
            if (push) mem[wptr] <= ld_tcdm_r_data_i[i*DW +: DW];
        end

        a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(push && !pop && (count == FULL_C) && !clear_i));

        assign ld_busy_o[i]              = busy;
        assign ld_done_o[i]              = done;
        assign ld_tcdm_req_o[i]          = req;
        assign ld_tcdm_add_o[i*AW +: AW] = addr;
        assign ld_valid_o[i]             = (count != '0);
        assign ld_data_o[i*DW +: DW]     = (count != '0) ? mem[rptr] : '0;
    end

    for (genvar j = 0; j < NB_ST; j++) begin : g_st
        st_state_e         state;
        logic [AW-1:0]     addr, stride;
        logic [LEN_W-1:0]  len, accepted, written, written_n;
        logic [DW-1:0]     data;
        logic              req, busy, done;
        logic              ready, accept, gnt_hit;
        logic [LEN_W-1:0]  len_in;

        assign len_in    = st_len_i[j*LEN_W +: LEN_W];
        assign gnt_hit   = req & st_tcdm_gnt_i[j];
        // The output register may refill in the same cycle it is granted.
        assign ready     = (state == ST_RUN) && (accepted < len) &&
                           (!req || st_tcdm_gnt_i[j]) && enable_i;
        assign accept    = st_valid_i[j] & ready;
        assign written_n = written + LEN_W'(gnt_hit);

        // Store FSM with one-entry output register.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state    <= ST_IDLE;
                addr     <= '0;
                stride   <= '0;
                len      <= '0;
                accepted <= '0;
                written  <= '0;
                data     <= '0;
                req      <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b0;
            end else if (clear_i) begin
                state    <= ST_IDLE;
                accepted <= '0;
                written  <= '0;
                req      <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b0;
            end else begin
                done <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (st_start_i[j]) begin
                            if (len_in != '0) begin
                                addr     <= st_base_i[j*AW +: AW];
                                stride   <= st_stride_i[j*AW +: AW];
                                len      <= len_in;
                                accepted <= '0;
                                written  <= '0;
                                busy     <= 1'b1;
                                state    <= ST_RUN;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        written <= written_n;
                        if (accept) begin
                            data     <= st_data_i[j*DW +: DW];
                            accepted <= accepted + LEN_W'(1);
                            req      <= 1'b1;
                        end else if (gnt_hit) begin
                            req <= 1'b0;
                        end
                        if (gnt_hit) begin
                            addr <= addr + stride;
                            if (written_n == len) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end

        assign st_busy_o[j]               = busy;
        assign st_done_o[j]               = done;
        assign st_ready_o[j]              = ready;
        assign st_tcdm_req_o[j]           = req;
        assign st_tcdm_add_o[j*AW +: AW]  = addr;
        assign st_tcdm_data_o[j*DW +: DW] = data;
    end

endmodule

// File: tb/tb_smmha_lin_streamer.sv
// Directed self-checking bench for smmha_lin_streamer (NB_LD=2, NB_ST=1).
// A TCDM model answers every granted read one cycle later with data = addr ^ 0x5A5A0000.
module tb_smmha_lin_streamer;
    localparam int unsigned NB_LD = 2;
    localparam int unsigned NB_ST = 1;
    localparam int unsigned DW    = 32;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic clear, enable;

    logic [NB_LD-1:0]       ld_start, ld_busy, ld_done, ld_req, ld_gnt, ld_valid, ld_ready;
    logic [NB_LD*32-1:0]    ld_base, ld_stride, ld_add;
    logic [NB_LD*LEN_W-1:0] ld_len;
    logic [NB_LD*DW-1:0]    ld_data;
    logic [NB_LD-1:0]       rvalid_q = '0;
    logic [NB_LD*DW-1:0]    rdata_q  = '0;

    logic [NB_ST-1:0]       st_start, st_busy, st_done, st_valid, st_ready, st_req, st_gnt;
    logic [31:0]            st_base, st_stride, st_add;
    logic [LEN_W-1:0]       st_len;
    logic [DW-1:0]          st_din, st_wdata;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    smmha_lin_streamer #(
        .NB_LD(NB_LD), .NB_ST(NB_ST), .DW(DW), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
        .ld_start_i(ld_start), .ld_base_i(ld_base), .ld_stride_i(ld_stride), .ld_len_i(ld_len),
        .ld_busy_o(ld_busy), .ld_done_o(ld_done),
        .ld_tcdm_req_o(ld_req), .ld_tcdm_add_o(ld_add), .ld_tcdm_gnt_i(ld_gnt),
        .ld_tcdm_r_data_i(rdata_q), .ld_tcdm_r_valid_i(rvalid_q),
        .ld_valid_o(ld_valid), .ld_data_o(ld_data), .ld_ready_i(ld_ready),
        .st_start_i(st_start), .st_base_i(st_base), .st_stride_i(st_stride), .st_len_i(st_len),
        .st_busy_o(st_busy), .st_done_o(st_done),
        .st_valid_i(st_valid), .st_data_i(st_din), .st_ready_o(st_ready),
        .st_tcdm_req_o(st_req), .st_tcdm_add_o(st_add), .st_tcdm_data_o(st_wdata),
        .st_tcdm_gnt_i(st_gnt)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // TCDM read model: data one cycle after grant
    always @(posedge clk) begin
        for (int i = 0; i < NB_LD; i++) begin
            rvalid_q[i]          <= ld_req[i] & ld_gnt[i];
            rdata_q[i*DW +: DW]  <= mem_f(ld_add[i*32 +: 32]);
        end
    end

    // Monitors sampled on the falling edge
    logic [31:0] ld_gaddr [NB_LD][$];
    int          ld_gcyc  [NB_LD][$];
    logic [31:0] ld_beat  [NB_LD][$];
    int          ld_done_cnt [NB_LD];
    int          ld_req_cnt  [NB_LD];
    int          ld_busy_cnt [NB_LD];
    logic [31:0] st_waddr [$];
    logic [31:0] st_wdat  [$];
    int          st_wcyc  [$];
    int          st_done_cnt = 0;
    int          st_done_cyc = 0;
    int          st_acc = 0;
    int          st_req_cnt = 0;
    int          st_busy_cnt = 0;

    initial begin
        for (int i = 0; i < NB_LD; i++) begin
            ld_done_cnt[i] = 0;
            ld_req_cnt[i]  = 0;
            ld_busy_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NB_LD; i++) begin
                if (ld_req[i] && ld_gnt[i]) begin
                    ld_gaddr[i].push_back(ld_add[i*32 +: 32]);
                    ld_gcyc[i].push_back(cyc);
                end
                if (ld_valid[i] && ld_ready[i]) ld_beat[i].push_back(ld_data[i*DW +: DW]);
                if (ld_done[i]) ld_done_cnt[i]++;
                if (ld_req[i])  ld_req_cnt[i]++;
                if (ld_busy[i]) ld_busy_cnt[i]++;
            end
            if (st_req[0] && st_gnt[0]) begin
                st_waddr.push_back(st_add);
                st_wdat.push_back(st_wdata);
                st_wcyc.push_back(cyc);
            end
            if (st_done[0]) begin
                st_done_cnt++;
                st_done_cyc = cyc;
            end
            if (st_valid[0] && st_ready[0]) st_acc++;
            if (st_req[0])  st_req_cnt++;
            if (st_busy[0]) st_busy_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ld_done(input int ch, input int base_cnt, input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            if (ld_done_cnt[ch] != base_cnt) break;
            tick();
        end
    endtask

    task automatic set_ld(input int ch, input logic [31:0] base, input logic [31:0] stride,
                          input logic [LEN_W-1:0] len);
        ld_base[ch*32 +: 32]      = base;
        ld_stride[ch*32 +: 32]    = stride;
        ld_len[ch*LEN_W +: LEN_W] = len;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, bb, d, a0, late, r0, bu0, sr0, sb0, sd0, w0;
        rst_n = 1'b0; clear = 1'b0; enable = 1'b1;
        ld_start = '0; ld_base = '0; ld_stride = '0; ld_len = '0; ld_gnt = '0; ld_ready = '0;
        st_start = '0; st_base = '0; st_stride = '0; st_len = '0; st_valid = '0; st_din = '0;
        st_gnt = '0;
        repeat (2) tick();

        // reset state
        check("rst_ld_busy_done", 32'({ld_busy, ld_done}), 32'h0);
        check("rst_ld_req_valid", 32'({ld_req, ld_valid}), 32'h0);
        check("rst_ld_add", ld_add[31:0] | ld_add[63:32], 32'h0);
        check("rst_ld_data", ld_data[31:0] | ld_data[63:32], 32'h0);
        check("rst_st_flags", 32'({st_busy, st_done, st_ready, st_req}), 32'h0);
        check("rst_st_add_data", st_add | st_wdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: straight load, full throughput
        b = ld_gaddr[0].size(); bb = ld_beat[0].size(); d = ld_done_cnt[0];
        set_ld(0, 32'h1000, 32'h4, 16'd8);
        ld_gnt = 2'b11; ld_ready = 2'b11;
        ld_start = 2'b01; tick(); ld_start = '0;
        wait_ld_done(0, d, 100);
        repeat (3) tick();
        check("t1_done_cnt", 32'(ld_done_cnt[0] - d), 32'd1);
        check("t1_grants", 32'(ld_gaddr[0].size() - b), 32'd8);
        check("t1_beats", 32'(ld_beat[0].size() - bb), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (b + k < ld_gaddr[0].size()) begin
                check("t1_addr", ld_gaddr[0][b+k], 32'h1000 + 32'(4*k));
                check("t1_gap", 32'(ld_gcyc[0][b+k] - ld_gcyc[0][b]), 32'(k));
            end
            if (bb + k < ld_beat[0].size())
                check("t1_data", ld_beat[0][bb+k], mem_f(32'h1000 + 32'(4*k)));
        end
        check("t1_busy_end", 32'(ld_busy[0]), 32'd0);

        // 2: credit throttling with stalled consumer
        b = ld_gaddr[0].size(); bb = ld_beat[0].size(); d = ld_done_cnt[0];
        set_ld(0, 32'h3000, 32'h4, 16'd10);
        ld_ready = 2'b10;
        ld_start = 2'b01; tick(); ld_start = '0;
        repeat (20) tick();
        check("t2_grants_stalled", 32'(ld_gaddr[0].size() - b), 32'd4);
        check("t2_req_low", 32'(ld_req[0]), 32'd0);
        check("t2_valid_held", 32'(ld_valid[0]), 32'd1);
        check("t2_head", ld_data[31:0], mem_f(32'h3000));
        repeat (3) tick();
        check("t2_head_stable", ld_data[31:0], mem_f(32'h3000));
        ld_ready = 2'b11;
        wait_ld_done(0, d, 100);
        tick();
        check("t2_done_cnt", 32'(ld_done_cnt[0] - d), 32'd1);
        check("t2_beats", 32'(ld_beat[0].size() - bb), 32'd10);
        for (int k = 0; k < 10; k++)
            if (bb + k < ld_beat[0].size())
                check("t2_data", ld_beat[0][bb+k], mem_f(32'h3000 + 32'(4*k)));

        // 3: store with toggling grant
        w0 = st_waddr.size(); a0 = st_acc; sd0 = st_done_cnt; late = 0;
        st_base = 32'h2000; st_stride = 32'h8; st_len = 16'd5;
        st_valid = 1'b1; st_gnt = 1'b1; st_din = 32'hC0DE_0000;
        st_start = 1'b1; tick(); st_start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (st_done_cnt != sd0) break;
            if ((st_acc - a0 == 5) && st_ready[0]) late++;
            st_gnt = ~st_gnt;
            st_din = 32'hC0DE_0000 + 32'(st_acc - a0);
            tick();
        end
        st_valid = 1'b0;
        repeat (2) tick();
        check("t3_done_cnt", 32'(st_done_cnt - sd0), 32'd1);
        check("t3_writes", 32'(st_waddr.size() - w0), 32'd5);
        for (int k = 0; k < 5; k++)
            if (w0 + k < st_waddr.size()) begin
                check("t3_addr", st_waddr[w0+k], 32'h2000 + 32'(8*k));
                check("t3_data", st_wdat[w0+k], 32'hC0DE_0000 + 32'(k));
            end
        if (st_wcyc.size() > 0)
            check("t3_done_lat", 32'(st_done_cyc - st_wcyc[st_wcyc.size()-1]), 32'd1);
        check("t3_ready_after_last", 32'(late), 32'd0);
        check("t3_busy_end", 32'({st_busy[0], st_ready[0]}), 32'd0);

        // 4: zero-length starts
        d = ld_done_cnt[0]; sd0 = st_done_cnt;
        r0 = ld_req_cnt[0]; bu0 = ld_busy_cnt[0]; sr0 = st_req_cnt; sb0 = st_busy_cnt;
        set_ld(0, 32'h5000, 32'h4, 16'd0);
        st_len = 16'd0;
        ld_start = 2'b01; st_start = 1'b1; tick(); ld_start = '0; st_start = 1'b0;
        check("t4_ld_done_pulse", 32'(ld_done[0]), 32'd1);
        check("t4_st_done_pulse", 32'(st_done[0]), 32'd1);
        tick();
        check("t4_done_drop", 32'({ld_done[0], st_done[0]}), 32'd0);
        repeat (3) tick();
        check("t4_ld_done_cnt", 32'(ld_done_cnt[0] - d), 32'd1);
        check("t4_st_done_cnt", 32'(st_done_cnt - sd0), 32'd1);
        check("t4_no_req", 32'((ld_req_cnt[0] - r0) + (st_req_cnt - sr0)), 32'd0);
        check("t4_no_busy", 32'((ld_busy_cnt[0] - bu0) + (st_busy_cnt - sb0)), 32'd0);

        // 5: independent channels, ch1 stalled by grant
        b = ld_gaddr[1].size(); bb = ld_beat[0].size(); d = ld_done_cnt[0];
        set_ld(0, 32'h1100, 32'h4, 16'd6);
        set_ld(1, 32'h8000, 32'h10, 16'd3);
        ld_gnt = 2'b01; ld_ready = 2'b11;
        ld_start = 2'b11; tick(); ld_start = '0;
        wait_ld_done(0, d, 100);
        tick();
        check("t5_ch0_done", 32'(ld_done_cnt[0] - d), 32'd1);
        check("t5_ch0_beats", 32'(ld_beat[0].size() - bb), 32'd6);
        for (int k = 0; k < 6; k++)
            if (bb + k < ld_beat[0].size())
                check("t5_ch0_data", ld_beat[0][bb+k], mem_f(32'h1100 + 32'(4*k)));
        check("t5_ch1_hold", 32'({ld_req[1], ld_busy[1]}), 32'h3);
        check("t5_ch1_addr", ld_add[63:32], 32'h8000);
        set_ld(1, 32'h9000, 32'h4, 16'd2);
        ld_start = 2'b10; tick(); ld_start = '0;
        repeat (4) tick();
        check("t5_ch1_restart_ign", ld_add[63:32], 32'h8000);
        check("t5_ch1_req_held", 32'(ld_req[1]), 32'd1);
        d = ld_done_cnt[1]; bb = ld_beat[1].size();
        ld_gnt = 2'b11;
        wait_ld_done(1, d, 100);
        tick();
        check("t5_ch1_done", 32'(ld_done_cnt[1] - d), 32'd1);
        check("t5_ch1_grants", 32'(ld_gaddr[1].size() - b), 32'd3);
        for (int k = 0; k < 3; k++)
            if (b + k < ld_gaddr[1].size())
                check("t5_ch1_addr", ld_gaddr[1][b+k], 32'h8000 + 32'(16*k));
        for (int k = 0; k < 3; k++)
            if (bb + k < ld_beat[1].size())
                check("t5_ch1_data", ld_beat[1][bb+k], mem_f(32'h8000 + 32'(16*k)));

        // 6: address wrap, clear alongside third grant, clean restart
        b = ld_gaddr[0].size(); d = ld_done_cnt[0];
        set_ld(0, 32'hFFFF_FFF8, 32'h4, 16'd4);
        ld_gnt = 2'b01; ld_ready = 2'b10;
        ld_start = 2'b01; tick(); ld_start = '0;
        for (int k = 0; k < 20; k++) begin
            if (ld_gaddr[0].size() - b >= 2) break;
            tick();
        end
        clear = 1'b1; tick(); clear = 1'b0;
        check("t6_clr_flags", 32'({ld_req[0], ld_valid[0], ld_busy[0]}), 32'd0);
        tick();
        check("t6_late_rvalid_drop", 32'(ld_valid[0]), 32'd0);
        repeat (3) tick();
        check("t6_valid_after", 32'({ld_valid[0], ld_req[0]}), 32'd0);
        check("t6_grants", 32'(ld_gaddr[0].size() - b), 32'd3);
        if (b + 2 < ld_gaddr[0].size()) begin
            check("t6_addr0", ld_gaddr[0][b],   32'hFFFF_FFF8);
            check("t6_addr1", ld_gaddr[0][b+1], 32'hFFFF_FFFC);
            check("t6_addr2", ld_gaddr[0][b+2], 32'h0000_0000);
        end
        check("t6_no_done", 32'(ld_done_cnt[0] - d), 32'd0);
        bb = ld_beat[0].size();
        set_ld(0, 32'h40, 32'h4, 16'd2);
        ld_ready = 2'b11; enable = 1'b0;
        ld_start = 2'b01; tick(); ld_start = '0;
        repeat (5) tick();
        check("t6_enable_gate", 32'({ld_busy[0], ld_req[0]}), 32'h2);
        enable = 1'b1;
        wait_ld_done(0, d, 100);
        tick();
        check("t6_restart_done", 32'(ld_done_cnt[0] - d), 32'd1);
        check("t6_restart_beats", 32'(ld_beat[0].size() - bb), 32'd2);
        for (int k = 0; k < 2; k++)
            if (bb + k < ld_beat[0].size())
                check("t6_restart_data", ld_beat[0][bb+k], mem_f(32'h40 + 32'(4*k)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
